// File: rtl/run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// run_ctrl_pkg
// Shared types and constants for the run/step/breakpoint controller that sits
// between the clock source and the multicycle RISC240 core.
//   rc_state_t   : controller state as seen on the rc_state output
//   halt_cause_t : reason the controller last stopped, seen on halt_cause
//   TRACE_DEPTH  : entries in the optional PC trace buffer
//   idx_width()  : index width for a bank of n entries, never below 1 bit
// ---------------------------------------------------------------------------
package run_ctrl_pkg;

    localparam int TRACE_DEPTH = 8;
    localparam int TRACE_PTR_W = 3;

    typedef enum logic [1:0] {
        RC_HALTED   = 2'd0,
        RC_RUNNING  = 2'd1,
        RC_STEPPING = 2'd2
    } rc_state_t;

    typedef enum logic [2:0] {
        HC_NONE    = 3'd0,
        HC_RESET   = 3'd1,
        HC_STEP    = 3'd2,
        HC_BREAK   = 3'd3,
        HC_HALTREQ = 3'd4,
        HC_TIMEOUT = 3'd5
    } halt_cause_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_control_bp_bank.sv
// ---------------------------------------------------------------------------
// bp_bank
// Bank of NUM_BP breakpoint registers (address + enable) compared in parallel
// against the core PC.
// Ports:
//   clock, reset       : system clock, async active-high reset (clears slots)
//   bp_we/bp_idx       : write strobe and slot select
//   bp_addr/bp_en      : address and enable written into the selected slot
//   pc                 : core PC to compare against
//   hit                : at least one enabled slot matches pc
//   hit_idx            : lowest matching slot index (0 when no hit)
// Writes land in the registers at the clock edge, so a slot written in the
// same cycle it matches still compares with its old contents.
// ---------------------------------------------------------------------------
module bp_bank
    import run_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int NUM_BP = 4,
    localparam int IDX_W = idx_width(NUM_BP)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bp_we,
    input  logic [IDX_W-1:0]  bp_idx,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] pc,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx
);

    logic [ADDR_W-1:0] addr_q [NUM_BP];
    logic [ADDR_W-1:0] addr_d [NUM_BP];
    logic [NUM_BP-1:0] en_q;
    logic [NUM_BP-1:0] en_d;
    logic [NUM_BP-1:0] match;

    // Slot write decode; an index beyond the bank (non power-of-two NUM_BP)
    // writes nothing.
    always_comb begin
        addr_d = addr_q;
        en_d   = en_q;
        if (bp_we) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (IDX_W'(i) == bp_idx) begin
                    addr_d[i] = bp_addr;
                    en_d[i]   = bp_en;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BP; i++) begin
                addr_q[i] <= '0;
            end
            en_q <= '0;
        end else begin
            addr_q <= addr_d;
            en_q   <= en_d;
        end
    end

    // Scan from the top down so the lowest matching slot wins.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            match[i] = en_q[i] && (addr_q[i] == pc);
        end
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
        hit = |match;
    end

endmodule

// File: rtl/run_control.sv
// ---------------------------------------------------------------------------
// run_control
// Run/step/breakpoint controller for the multicycle RISC240 core. Produces a
// per-cycle cpu_en that gates every core register update and memory write,
// and adds hardware halt, single-instruction step, a PC breakpoint bank and a
// cycle-count timeout.
// Ports:
//   clock, reset            : system clock, async active-high reset
//   run_req/step_req/halt_req : single-cycle control pulses
//   fetch, pc               : core is at FETCH (instruction boundary), core PC
//   bp_we/bp_idx/bp_addr/bp_en : breakpoint slot write
//   cpu_en                  : core advances this cycle (combinational)
//   rc_state, halt_cause, halt_bp : controller status for LEDs
//   cycle_count             : enabled cycles since reset, saturating
//   trace_idx, trace_pc     : PC trace read port (0 = newest, 1-cycle latency)
// Optional feature macro: RUN_CTRL_PC_TRACE_EN enables the 8-entry PC trace
// buffer; without it trace_pc is tied to 0.
// ---------------------------------------------------------------------------
module run_control
    import run_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int NUM_BP     = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 50000,
    localparam int BP_IDX_W  = idx_width(NUM_BP)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run_req,
    input  logic                step_req,
    input  logic                halt_req,
    input  logic                fetch,
    input  logic [ADDR_W-1:0]   pc,
    input  logic                bp_we,
    input  logic [BP_IDX_W-1:0] bp_idx,
    input  logic [ADDR_W-1:0]   bp_addr,
    input  logic                bp_en,
    output logic                cpu_en,
    output logic [1:0]          rc_state,
    output logic [2:0]          halt_cause,
    output logic [BP_IDX_W-1:0] halt_bp,
    output logic [CNT_W-1:0]    cycle_count,
    input  logic [2:0]          trace_idx,
    output logic [ADDR_W-1:0]   trace_pc
);

    localparam bit               TIMEOUT_ON = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0] MAX_COUNT  = CNT_W'(MAX_CYCLES);

    rc_state_t             rc_state_q,     rc_state_d;
    halt_cause_t           halt_cause_q,   halt_cause_d;
    logic [BP_IDX_W-1:0]   halt_bp_q,      halt_bp_d;
    logic [CNT_W-1:0]      cycle_count_q,  cycle_count_d;
    logic                  halt_pending_q, halt_pending_d;
    logic                  first_q,        first_d;
    logic                  timed_out_q,    timed_out_d;

    logic                  bp_hit;
    logic [BP_IDX_W-1:0]   bp_hit_idx;
    logic                  active;
    logic                  timeout_hit;
    logic                  boundary;
    logic                  stop_now;
    halt_cause_t           stop_cause;

    bp_bank #(
        .ADDR_W (ADDR_W),
        .NUM_BP (NUM_BP)
    ) u_bp_bank (
        .clock   (clock),
        .reset   (reset),
        .bp_we   (bp_we),
        .bp_idx  (bp_idx),
        .bp_addr (bp_addr),
        .bp_en   (bp_en),
        .pc      (pc),
        .hit     (bp_hit),
        .hit_idx (bp_hit_idx)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rc_state_q     <= RC_HALTED;
            halt_cause_q   <= HC_RESET;
            halt_bp_q      <= '0;
            cycle_count_q  <= '0;
            halt_pending_q <= 1'b0;
            first_q        <= 1'b0;
            timed_out_q    <= 1'b0;
        end else begin
            rc_state_q     <= rc_state_d;
            halt_cause_q   <= halt_cause_d;
            halt_bp_q      <= halt_bp_d;
            cycle_count_q  <= cycle_count_d;
            halt_pending_q <= halt_pending_d;
            first_q        <= first_d;
            timed_out_q    <= timed_out_d;
        end
    end

    // Stop detection. The timeout may cut an instruction short; boundary
    // stops are skipped on the first enabled cycle so the core can leave the
    // FETCH it was halted on (including a breakpoint address).
    always_comb begin
        active      = (rc_state_q != RC_HALTED);
        timeout_hit = TIMEOUT_ON && active && (cycle_count_q == MAX_COUNT);
        boundary    = fetch && !first_q && active;
        stop_now    = 1'b0;
        stop_cause  = HC_NONE;
        if (timeout_hit) begin
            stop_now   = 1'b1;
            stop_cause = HC_TIMEOUT;
        end else if (boundary) begin
            if (halt_pending_q) begin
                stop_now   = 1'b1;
                stop_cause = HC_HALTREQ;
            end else if (bp_hit) begin
                stop_now   = 1'b1;
                stop_cause = HC_BREAK;
            end else if (rc_state_q == RC_STEPPING) begin
                stop_now   = 1'b1;
                stop_cause = HC_STEP;
            end
        end
    end

    // Next-state logic. A halt_req arriving together with run/step while
    // halted cancels the start; after a timeout only reset can restart.
    always_comb begin
        rc_state_d     = rc_state_q;
        halt_cause_d   = halt_cause_q;
        halt_bp_d      = halt_bp_q;
        halt_pending_d = halt_pending_q;
        first_d        = first_q;
        timed_out_d    = timed_out_q;
        case (rc_state_q)
            RC_HALTED: begin
                if (!timed_out_q && !halt_req && (run_req || step_req)) begin
                    rc_state_d   = run_req ? RC_RUNNING : RC_STEPPING;
                    first_d      = 1'b1;
                    halt_cause_d = HC_NONE;
                end
            end
            RC_RUNNING, RC_STEPPING: begin
                if (stop_now) begin
                    rc_state_d     = RC_HALTED;
                    halt_cause_d   = stop_cause;
                    halt_pending_d = 1'b0;
                    first_d        = 1'b0;
                    if (stop_cause == HC_BREAK) begin
                        halt_bp_d = bp_hit_idx;
                    end
                    if (stop_cause == HC_TIMEOUT) begin
                        timed_out_d = 1'b1;
                    end
                end else begin
                    if (halt_req) begin
                        halt_pending_d = 1'b1;
                    end
                    first_d = 1'b0;
                end
            end
            default: begin
                rc_state_d = RC_HALTED;
            end
        endcase
    end

    // Outputs and the saturating enabled-cycle counter.
    always_comb begin
        cpu_en        = active && !stop_now;
        cycle_count_d = cycle_count_q;
        if (cpu_en && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + 1'b1;
        end
    end

    assign rc_state    = rc_state_q;
    assign halt_cause  = halt_cause_q;
    assign halt_bp     = halt_bp_q;
    assign cycle_count = cycle_count_q;

`ifdef RUN_CTRL_PC_TRACE_EN
    logic [ADDR_W-1:0]      trace_buf_q [TRACE_DEPTH];
    logic [ADDR_W-1:0]      trace_buf_d [TRACE_DEPTH];
    logic [TRACE_PTR_W-1:0] trace_wr_q, trace_wr_d;
    logic [TRACE_PTR_W-1:0] trace_rd;
    logic [ADDR_W-1:0]      trace_pc_q, trace_pc_d;

    // trace_wr_q points at the slot the next capture lands in, so the newest
    // entry is one behind it. The read sees the buffer before this cycle's
    // capture.
    always_comb begin
        trace_buf_d = trace_buf_q;
        trace_wr_d  = trace_wr_q;
        trace_rd    = trace_wr_q - 3'd1 - trace_idx;
        trace_pc_d  = trace_buf_q[trace_rd];
        if (cpu_en && fetch) begin
            trace_buf_d[trace_wr_q] = pc;
            trace_wr_d              = trace_wr_q + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                trace_buf_q[i] <= '0;
            end
            trace_wr_q <= '0;
            trace_pc_q <= '0;
        end else begin
            trace_buf_q <= trace_buf_d;
            trace_wr_q  <= trace_wr_d;
            trace_pc_q  <= trace_pc_d;
        end
    end

    assign trace_pc = trace_pc_q;
`else
    logic unused_trace_idx;
    assign unused_trace_idx = ^trace_idx;
    assign trace_pc         = '0;
`endif

endmodule
